// File: rtl/router_sw_alloc_pkg.sv
// -----------------------------------------------------------------------------
// router_sw_alloc_pkg
//   Shared definitions for the mesh-router switch allocator: port codes,
//   field widths, the per-output allocation state and a round-robin helper.
// -----------------------------------------------------------------------------
package router_sw_alloc_pkg;

  // Port codes as produced by the route stage. Code 0 is always local.
  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NB1   = 3'd1;
  localparam logic [2:0] PORT_NB2   = 3'd2;
  localparam logic [2:0] PORT_NB3   = 3'd3;

  // Width of a route result / crossbar select slice, and of an input index.
  localparam int PORT_W = 3;
  localparam int OWN_W  = 2;

  // Per-output allocation state.
  typedef enum logic {
    SA_IDLE = 1'b0,
    SA_LOCK = 1'b1
  } sa_state_e;

  // Round-robin successor of an input index, wrapping at nport.
  function automatic logic [OWN_W-1:0] rr_next(input logic [OWN_W-1:0] idx,
                                               input int               nport);
    if (int'(idx) + 1 >= nport) return '0;
    return idx + OWN_W'(1);
  endfunction

endpackage : router_sw_alloc_pkg

// File: rtl/router_rr_arb.sv
// -----------------------------------------------------------------------------
// router_rr_arb
//   Combinational NPORT-wide round-robin picker. Scans the request vector
//   starting at rr_ptr and wrapping at NPORT; the first set request wins.
//
//   Ports:
//     req      in  NPORT  request vector, bit i = input i requests
//     rr_ptr   in  2      index where the scan starts
//     gnt      out NPORT  one-hot grant (all zero when nothing requests)
//     gnt_idx  out 2      index of the winner (0 when nothing requests)
// -----------------------------------------------------------------------------
module router_rr_arb
  import router_sw_alloc_pkg::*;
#(
  parameter int NPORT = 4
) (
  input  logic [NPORT-1:0] req,
  input  logic [OWN_W-1:0] rr_ptr,
  output logic [NPORT-1:0] gnt,
  output logic [OWN_W-1:0] gnt_idx
);

  logic found;
  int   idx;

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NPORT; k++) begin
      // rr_ptr + k is at most 2*NPORT-2, so a single subtract wraps it.
      idx = int'(rr_ptr) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = OWN_W'(idx);
      end
    end
  end

endmodule : router_rr_arb

// File: rtl/router_sw_alloc.sv
// -----------------------------------------------------------------------------
// router_sw_alloc
//   Switch allocator for one mesh router (3-port corner or 4-port edge).
//   Each output port owns a two-state machine (IDLE / LOCK). In IDLE it grants
//   itself round-robin to one requesting input; in LOCK it passes that input's
//   flits until the tail transfers, then releases and advances its pointer
//   past the old owner. A grant sampled at one edge produces its first
//   transfer in the following cycle, so there is one bubble per packet.
//
//   Ports:
//     clk        in  1          rising-edge clock
//     rst_n      in  1          asynchronous active-low reset
//     en         in  1          global enable; 0 freezes state, blanks outputs
//     in_valid   in  NPORT      input i has a flit at its buffer head
//     in_tail    in  NPORT      head flit of input i is a tail
//     in_port    in  3*NPORT    route result of input i, slice [3i+2:3i]
//     out_ready  in  NPORT      downstream of output o accepts a flit
//     in_pop     out NPORT      flit of input i transfers this cycle
//     out_valid  out NPORT      output o carries a flit this cycle
//     out_sel    out 3*NPORT    crossbar select (owning input) of output o
//     err_port   out 1          sticky: a request named a nonexistent port
// -----------------------------------------------------------------------------
module router_sw_alloc
  import router_sw_alloc_pkg::*;
#(
  parameter int NPORT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NPORT-1:0]      in_valid,
  input  logic [NPORT-1:0]      in_tail,
  input  logic [PORT_W*NPORT-1:0] in_port,
  input  logic [NPORT-1:0]      out_ready,
  output logic [NPORT-1:0]      in_pop,
  output logic [NPORT-1:0]      out_valid,
  output logic [PORT_W*NPORT-1:0] out_sel,
  output logic                  err_port
);

  // Per-output state
  sa_state_e        state_q  [NPORT];
  sa_state_e        state_d  [NPORT];
  logic [OWN_W-1:0] owner_q  [NPORT];
  logic [OWN_W-1:0] owner_d  [NPORT];
  logic [OWN_W-1:0] rr_ptr_q [NPORT];
  logic [OWN_W-1:0] rr_ptr_d [NPORT];
  logic             err_port_q;
  logic             err_port_d;

  // Arbitration plumbing
  logic [NPORT-1:0] owns_any;
  logic [NPORT-1:0] req     [NPORT];
  logic [NPORT-1:0] gnt     [NPORT];
  logic [OWN_W-1:0] gnt_idx [NPORT];

  // An input that already owns an output may not request another one; its
  // route field is stale while it is mid-packet.
  always_comb begin
    owns_any = '0;
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (state_q[o] == SA_LOCK && owner_q[o] == OWN_W'(i)) owns_any[i] = 1'b1;
      end
    end
  end

  // Request matrix: req[o][i] = input i wants output o. Route codes >= NPORT
  // never match any output, so bad routes are never granted.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        req[o][i] = in_valid[i] && !owns_any[i] &&
                    (in_port[PORT_W*i +: PORT_W] == PORT_W'(o));
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    router_rr_arb #(
      .NPORT (NPORT)
    ) u_arb (
      .req     (req[o]),
      .rr_ptr  (rr_ptr_q[o]),
      .gnt     (gnt[o]),
      .gnt_idx (gnt_idx[o])
    );
  end

  // Next-state and output logic. Outputs depend only on registered ownership
  // plus the live valid/ready handshake, never on this cycle's arbitration,
  // which is what makes a release and a regrant take two separate edges.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    err_port_d = err_port_q;
    in_pop     = '0;
    out_valid  = '0;
    out_sel    = '0;

    if (en) begin
      for (int o = 0; o < NPORT; o++) begin
        unique case (state_q[o])
          SA_IDLE: begin
            if (|gnt[o]) begin
              state_d[o] = SA_LOCK;
              owner_d[o] = gnt_idx[o];
            end
          end
          SA_LOCK: begin
            out_sel[PORT_W*o +: PORT_W] = {1'b0, owner_q[o]};
            for (int i = 0; i < NPORT; i++) begin
              if (owner_q[o] == OWN_W'(i) && in_valid[i] && out_ready[o]) begin
                out_valid[o] = 1'b1;
                in_pop[i]    = 1'b1;
                if (in_tail[i]) begin
                  state_d[o]  = SA_IDLE;
                  rr_ptr_d[o] = rr_next(owner_q[o], NPORT);
                end
              end
            end
          end
          default: ;
        endcase
      end

      for (int i = 0; i < NPORT; i++) begin
        if (in_valid[i] && !owns_any[i] &&
            in_port[PORT_W*i +: PORT_W] >= PORT_W'(NPORT)) begin
          err_port_d = 1'b1;
        end
      end
    end
  end

  // NOTE: the per-output arrays are small control registers, not storage,
  // so every element is reset; a reset mid-packet must drop all locks at once.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o]  <= SA_IDLE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= '0;
      end
      err_port_q <= 1'b0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
      end
      err_port_q <= err_port_d;
    end
  end

  assign err_port = err_port_q;

endmodule : router_sw_alloc

// File: tb/tb_router_sw_alloc.sv
// -----------------------------------------------------------------------------
// tb_router_sw_alloc
//   Drives a 4-port and a 3-port allocator side by side. A packet-level
//   reference model (each output either free or held by one input, plus a
//   "next to favour" index) predicts every output every cycle. Directed
//   scenarios add fixed expectations on top of the model.
// -----------------------------------------------------------------------------
module tb_router_sw_alloc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;

  logic [3:0]  v4, t4, r4, pop4, ov4;
  logic [11:0] p4, sel4;
  logic        err4;
  logic [2:0]  v3, t3, r3, pop3, ov3;
  logic [8:0]  p3, sel3;
  logic        err3;

  always #5 clk = ~clk;

  router_sw_alloc #(.NPORT(4)) dut4 (
    .clk (clk), .rst_n (rst_n), .en (en),
    .in_valid (v4), .in_tail (t4), .in_port (p4), .out_ready (r4),
    .in_pop (pop4), .out_valid (ov4), .out_sel (sel4), .err_port (err4)
  );

  router_sw_alloc #(.NPORT(3)) dut3 (
    .clk (clk), .rst_n (rst_n), .en (en),
    .in_valid (v3), .in_tail (t3), .in_port (p3), .out_ready (r3),
    .in_pop (pop3), .out_valid (ov3), .out_sel (sel3), .err_port (err3)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus, indexed [dut][port]; dut 0 has 4 ports, dut 1 has 3.
  bit iv [2][4];
  bit it [2][4];
  bit ir [2][4];
  int ip [2][4];
  bit en_i;
  bit rst_i;

  // Reference model: holder[o] = input currently holding output o, -1 if free;
  // favour[o] = first input to consider next time output o is free.
  int holder [2][4];
  int favour [2][4];
  bit err_m  [2];

  // Expected outputs for the current cycle.
  bit ev   [2][4];
  bit epop [2][4];
  int esel [2][4];
  bit eerr [2];

  task automatic model_step(input int d, input int np);
    bit busy [4];
    int nh   [4];
    for (int o = 0; o < 4; o++) begin
      ev[d][o] = 0; epop[d][o] = 0; esel[d][o] = 0;
    end
    if (!rst_i) begin
      for (int o = 0; o < 4; o++) begin
        holder[d][o] = -1; favour[d][o] = 0;
      end
      err_m[d] = 0;
      eerr[d]  = 0;
      return;
    end
    eerr[d] = err_m[d];
    if (!en_i) return;
    for (int i = 0; i < 4; i++) busy[i] = 0;
    for (int o = 0; o < np; o++) if (holder[d][o] >= 0) busy[holder[d][o]] = 1;
    for (int o = 0; o < np; o++) begin
      nh[o] = holder[d][o];
      if (holder[d][o] >= 0) begin
        int h = holder[d][o];
        esel[d][o] = h;
        if (iv[d][h] && ir[d][o]) begin
          ev[d][o] = 1; epop[d][h] = 1;
          if (it[d][h]) begin
            nh[o] = -1;
            favour[d][o] = (h + 1) % np;
          end
        end
      end else begin
        for (int k = 0; k < np; k++) begin
          int i = (favour[d][o] + k) % np;
          if (nh[o] < 0 && iv[d][i] && !busy[i] && ip[d][i] == o) nh[o] = i;
        end
      end
    end
    for (int i = 0; i < np; i++)
      if (iv[d][i] && !busy[i] && ip[d][i] >= np) err_m[d] = 1;
    for (int o = 0; o < np; o++) holder[d][o] = nh[o];
  endtask

  task automatic compare(input int d);
    logic [3:0]  gv, gp, xv, xp;
    logic [11:0] gs, xs;
    logic        ge;
    if (d == 0) begin
      gv = ov4; gp = pop4; gs = sel4; ge = err4;
    end else begin
      gv = {1'b0, ov3}; gp = {1'b0, pop3}; gs = {3'b0, sel3}; ge = err3;
    end
    xs = '0;
    for (int o = 0; o < 4; o++) begin
      xv[o] = ev[d][o];
      xp[o] = epop[d][o];
      xs[3*o +: 3] = 3'(esel[d][o]);
    end
    check($sformatf("d%0d out_valid", d), 32'(gv), 32'(xv));
    check($sformatf("d%0d in_pop", d),    32'(gp), 32'(xp));
    check($sformatf("d%0d out_sel", d),   32'(gs), 32'(xs));
    check($sformatf("d%0d err_port", d),  32'(ge), 32'(eerr[d]));
  endtask

  // One cycle: drive at the falling edge, compare just after, leave the
  // rising edge to commit the DUT state the model has already advanced to.
  task automatic tick();
    @(negedge clk);
    rst_n = rst_i;
    en    = en_i;
    for (int i = 0; i < 4; i++) begin
      v4[i] = iv[0][i]; t4[i] = it[0][i]; r4[i] = ir[0][i];
      p4[3*i +: 3] = 3'(ip[0][i]);
    end
    for (int i = 0; i < 3; i++) begin
      v3[i] = iv[1][i]; t3[i] = it[1][i]; r3[i] = ir[1][i];
      p3[3*i +: 3] = 3'(ip[1][i]);
    end
    #1;
    model_step(0, 4);
    model_step(1, 3);
    compare(0);
    compare(1);
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        iv[d][i] = 0; it[d][i] = 0; ir[d][i] = 1; ip[d][i] = 0;
      end
  endtask

  task automatic rand_inputs(input bit bad_ok);
    for (int d = 0; d < 2; d++) begin
      int np = (d == 0) ? 4 : 3;
      for (int i = 0; i < np; i++) begin
        iv[d][i] = ($urandom % 4) != 0;
        it[d][i] = ($urandom % 3) == 0;
        ir[d][i] = ($urandom % 5) != 0;
        if (bad_ok && ($urandom % 10) == 0) ip[d][i] = $urandom_range(7, np);
        else                                 ip[d][i] = $urandom % np;
      end
    end
  endtask

  initial begin
    int en_hold;
    rst_n = 1'b0; en = 1'b1;
    v4 = '0; t4 = '0; r4 = '0; p4 = '0;
    v3 = '0; t3 = '0; r3 = '0; p3 = '0;
    en_i = 1; rst_i = 0;
    clear_inputs();

    // Reset held with random inputs: every output must stay quiet.
    for (int c = 0; c < 4; c++) begin
      rand_inputs(1);
      tick();
      check("rst pop4", 32'(pop4), 32'h0);
      check("rst err4", 32'(err4), 32'h0);
    end
    rst_i = 1;
    clear_inputs();
    for (int c = 0; c < 3; c++) tick();

    // Single 3-flit packet: input 0 -> output 2.
    iv[0][0] = 1; ip[0][0] = 2;
    tick();
    check("sp bubble pop", 32'(pop4), 32'h0);
    for (int f = 0; f < 3; f++) begin
      it[0][0] = (f == 2);
      tick();
      check("sp pop", 32'(pop4), 32'h1);
      check("sp valid", 32'(ov4), 32'h4);
      check("sp sel2", 32'(sel4[8:6]), 32'h0);
    end
    clear_inputs();
    tick();
    check("sp idle", 32'(ov4), 32'h0);

    // Output 2 now favours input 1 over input 0.
    iv[0][0] = 1; ip[0][0] = 2; it[0][0] = 1;
    iv[0][1] = 1; ip[0][1] = 2; it[0][1] = 1;
    tick();
    tick();
    check("rr2 sel", 32'(sel4[8:6]), 32'h1);
    clear_inputs();
    tick(); tick();

    // Contention on output 0: 1 wins, then 3 wins ahead of a new input-0 request.
    iv[0][1] = 1; it[0][1] = 1;
    iv[0][3] = 1; it[0][3] = 1;
    tick();
    tick();
    check("ct first sel", 32'(sel4[2:0]), 32'h1);
    check("ct first pop", 32'(pop4), 32'h2);
    iv[0][1] = 0;
    iv[0][0] = 1; it[0][0] = 1;
    tick();
    check("ct release gap", 32'(ov4), 32'h0);
    tick();
    check("ct second sel", 32'(sel4[2:0]), 32'h3);
    check("ct second pop", 32'(pop4), 32'h8);
    clear_inputs();
    tick(); tick();

    // Bad route on input 1.
    iv[0][1] = 1; ip[0][1] = 5;
    tick();
    check("bad err before", 32'(err4), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bad err sticky", 32'(err4), 32'h1);
      check("bad no pop", 32'(pop4), 32'h0);
    end
    clear_inputs();
    rst_i = 0; tick();
    check("bad err cleared", 32'(err4), 32'h0);
    rst_i = 1;

    // Randomised traffic with freezes and occasional mid-packet resets.
    en_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      rand_inputs(c >= 2400);
      if (en_hold > 0) begin
        en_i = 0; en_hold--;
      end else begin
        en_i = 1;
        if (($urandom % 25) == 0) en_hold = $urandom_range(4, 1);
      end
      rst_i = ($urandom % 400) != 0;
      tick();
    end
    rst_i = 1; en_i = 1;
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_router_sw_alloc
